// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_4bit_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full adder built from gate primitives; the only datapath arithmetic.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic t, g, p;

  xor u_x0 (t, a, b);
  xor u_x1 (s, t, cin);
  and u_a0 (g, a, b);
  and u_a1 (p, t, cin);
  or  u_o0 (cout, g, p);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial a - b computed as a + ~b + 1, one bit per clock, LSB first.
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             overflow
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, nb_q, diff_q;
  logic [WIDTH-2:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, co_q, ov_q, busy_q, done_q;

  logic             s, cout;
  logic [WIDTH-1:0] sum_d;
  logic             ov_d;

  serial_fa_slice u_fa (
    .a   (a_q[0]),
    .b   (nb_q[0]),
    .cin (c_q),
    .s   (s),
    .cout(cout)
  );

  // Partial sums live in sr_q; diff only sees the word once it is complete.
  assign sum_d = {s, sr_q};
  // On the last bit a_q[0] is a's sign and nb_q[0] the inverted sign of b.
  assign ov_d  = (a_q[0] == nb_q[0]) && (s != a_q[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      diff_q  <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            nb_q    <= ~b;
            c_q     <= 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          nb_q  <= nb_q >> 1;
          c_q   <= cout;
          sr_q  <= sum_d[WIDTH-1:1];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= sum_d;
            co_q    <= cout;
            ov_q    <= ov_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign carryout = co_q;
  assign overflow = ov_q;

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, 2's complement, sampled on the start-capture edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, 2's complement, sampled on the start-capture edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN state).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b, 2's complement, modulo 2^WIDTH.
REQ-010 The block SHALL have port carryout, output, 1 bit: carry out of a + ~b + 1 (1 = no borrow).
REQ-011 The block SHALL have port overflow, output, 1 bit: the signed result is not representable in WIDTH bits.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the capture edge SHALL load a and ~b into shift registers, preset the carry flop to 1 and the bit counter to 0, and move to RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first, through one full-adder slice: sum bit shifted into the diff register MSB-first-from-top, carry flop updated, counter incremented.
REQ-015 After the edge processing bit WIDTH-1, the FSM SHALL enter DONE; carryout is the final carry; overflow = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
REQ-016 Latency: done SHALL be high for exactly the one cycle that begins WIDTH edges after the capture edge; the next edge returns to IDLE.
REQ-017 diff, carryout and overflow SHALL be updated only on the final RUN edge and SHALL hold until the next final RUN edge (stable through IDLE and across a new RUN).
REQ-018 Intermediate shift-register contents SHALL NOT be visible on diff; diff changes only at completion.
REQ-019 start SHALL be ignored in RUN and DONE (no queueing); start held high continuously gives back-to-back operations, one every WIDTH+2 cycles.
REQ-020 a and b SHALL be don't-care except on the capture edge.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, carryout=0, overflow=0, counter=0, carry flop=0, independent of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release is processed normally.
REQ-024 Release of rst_n SHALL take effect on the first rising clk edge with rst_n=1.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration and the default WIDTH constant (4).
REQ-026 The one-bit add slice SHALL be a combinational sub-module, serial_fa_slice (inputs a, b, cin; outputs s, cout), built from the team's delayed gate primitives.
REQ-027 The counter SHALL be sized clog2(WIDTH) bits; there SHALL be no other arithmetic on operand data outside serial_fa_slice.

Verification
REQ-028 Start with a=0101, b=0011 -> done 4 cycles after capture; diff=0010, carryout=1, overflow=0.
REQ-029 Start with a=0011, b=0101 -> diff=1110, carryout=0, overflow=0.
REQ-030 Start with a=0111, b=1111 -> diff=1000, carryout=0, overflow=1. Start with a=1000, b=0001 -> diff=0111, carryout=1, overflow=1.
REQ-031 Pulse start during RUN with different operands -> ignored; the result reflects the first operands; exactly one done pulse.
REQ-032 Deassert rst_n two cycles into RUN -> outputs are 0 immediately, no done pulse; after release, a=0001, b=0001 -> diff=0000, carryout=1, overflow=0.
REQ-033 Hold start=1 for 3 operations -> done pulses spaced WIDTH+2 cycles apart; diff is stable between pulses.
